// File: rtl/sub_pkg.sv
// Shared types for the serial subtractor datapath.
package sub_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/digit_subtractor.sv
// Combinational ripple of DIGIT full-subtract stages; also exposes the borrow
// entering the top bit so the caller can derive signed overflow.
module digit_subtractor #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo,
  output logic             btop
);

  logic [DIGIT:0] bc;

  always_comb begin
    bc    = '0;
    d     = '0;
    bc[0] = bi;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]    = x[i] ^ y[i] ^ bc[i];
      bc[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bc[i]);
    end
  end

  assign bo   = bc[DIGIT];
  assign btop = bc[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, DIGIT bits per clock, with start/busy/done handshake
// and borrow, zero and signed-overflow flags on completion.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        digBase;
  logic [DIGIT-1:0]   digX, digY, digD;
  logic               digBo, digBtop;

  assign digBase = 32'(cnt_q) * 32'(DIGIT);
  assign digX    = a_q[digBase +: DIGIT];
  assign digY    = b_q[digBase +: DIGIT];

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .x    (digX),
    .y    (digY),
    .bi   (borrow_q),
    .d    (digD),
    .bo   (digBo),
    .btop (digBtop)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d[digBase +: DIGIT] = digD;
        borrow_d = digBo;
        cnt_d    = cnt_q + 1'b1;
        // Last digit: the just-written slice completes the result, so flags use res_d.
        if (cnt_q == LAST) begin
          diff_d  = res_d;
          bout_d  = digBo;
          zero_d  = (res_d == '0);
          ovf_d   = digBo ^ digBtop;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle, parametrised signed/unsigned subtractor computing a - b - bin over WIDTH bits, DIGIT bits per clock, with a borrow register carried between digits. Generalises the 1-bit full subtractor into a reusable datapath unit for narrow-area arithmetic paths. Uses a start/busy/done handshake and reports borrow-out, zero and signed-overflow flags alongside the difference.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 1
DIGIT, 2, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0 (elaboration-time assertion)
N (localparam), WIDTH/DIGIT, RUN cycles per operation

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only on a rising edge while idle (busy=0)
a  input  WIDTH  minuend, sampled when start is accepted
b  input  WIDTH  subtrahend, sampled when start is accepted
bin  input  1  borrow-in, sampled when start is accepted
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid
diff  output  WIDTH  a - b - bin mod 2^WIDTH
bout  output  1  unsigned borrow-out (1 iff a < b + bin)
zero  output  1  diff == 0
ovf  output  1  signed overflow (signed a - signed b - bin not representable in WIDTH bits)

Behaviour:
- Reset (sync, active-high): state=IDLE, busy=0, done=0, diff=0, bout=0, zero=0, ovf=0, digit counter=0, borrow register=0. rst dominates start in the same cycle.
- FSM states: IDLE, RUN.
- IDLE: on an edge with start=1, latch a, b; borrow_reg<=bin; cnt<=0; go to RUN; busy=1 from the next cycle. Otherwise hold. done is cleared one cycle after it is raised.
- RUN: each edge subtracts digit cnt (bits [cnt*DIGIT +: DIGIT]) with borrow_reg via the digit slice, writes that digit of the result, updates borrow_reg, and increments cnt.
- On the edge where cnt==N-1: register final diff, bout=final borrow, zero, ovf (= borrow into MSB XOR borrow out of MSB); done<=1; busy<=0; go to IDLE.
- Latency: start accepted at edge k -> done=1 and results valid in the cycle after edge k+N; busy=1 for exactly N cycles.
- start while busy=1: ignored. Operand changes during RUN: ignored (latched copies used).
- start=1 during the done cycle: accepted (IDLE). done still lasts exactly one cycle. Results hold until the next completion.
- diff, bout, zero, ovf hold their last values between operations. They do not change during RUN. Only the internal shift/result register changes.
- DIGIT==WIDTH: N=1, single RUN cycle.
- Reset mid-RUN: operation aborted, no done pulse, all outputs return to reset values.

Decomposition:
- Package sub_pkg: state enum (IDLE, RUN).
- Sub-module digit_subtractor #(DIGIT): combinational ripple of DIGIT full-subtract stages (inputs x, y, bi; outputs d, bo, plus borrow into the top bit for ovf). Instantiated once in serial_subtractor.

Test Plan:
1. WIDTH=8, DIGIT=2: a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0, zero=0, ovf=0; done pulses 4 cycles after start accepted, busy high exactly 4 cycles.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0, zero=0.
3. a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x05, b=0x04, bin=1 -> diff=0x00, zero=1, bout=0.
4. Second start pulses during RUN with different operands -> ignored; result matches first operands. start asserted in the done cycle -> accepted; next done arrives 4 cycles later.
5. rst asserted for one cycle at RUN cycle 2 -> busy=0 and all outputs 0 the next cycle, no done pulse. A fresh start then completes correctly.
6. Exhaustive a, b in 0..255 and bin in {0,1} for DIGIT in {1,2,4,8} -> diff, bout, zero, ovf match the reference model every operation; latency = 8/DIGIT cycles.
